// File: rtl/vga_sync_if.sv
// Raster timing bundle from the sync generator to the pixel draw stage.
interface vga_sync_if;
  logic       Pixel_Tick_Out;
  logic       H_Sync_Out;
  logic       V_Sync_Out;
  logic       Disp_Ena_Out;
  logic [9:0] Pixel_X_Out;
  logic [9:0] Pixel_Y_Out;
  logic       Frame_Start_Out;

  modport master (
    output Pixel_Tick_Out, H_Sync_Out, V_Sync_Out, Disp_Ena_Out,
           Pixel_X_Out, Pixel_Y_Out, Frame_Start_Out
  );

  modport slave (
    input Pixel_Tick_Out, H_Sync_Out, V_Sync_Out, Disp_Ena_Out,
          Pixel_X_Out, Pixel_Y_Out, Frame_Start_Out
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 raster timing generator: clock divider, H/V counters and
// registered sync / display-enable / coordinate outputs.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_In,
  vga_sync_if.master vga
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       tick_q, tick_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;
  logic       adv;

  always_comb begin
    adv   = (div_q == DIV_LAST);
    div_d = adv ? '0 : div_q + 4'd1;
    x_d   = x_q;
    y_d   = y_q;
    fs_d  = 1'b0;
    if (adv) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    tick_d = adv;
    // Decode from the next counter values so flags and coordinates share one edge.
    de_d = (x_d < X_ACT) && (y_d < Y_ACT);
    hs_d = ((x_d >= HS_BEG) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_d = ((y_d >= VS_BEG) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge Master_Clock_In) begin
    if (Reset_In) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      tick_q <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tick_q <= tick_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      fs_q   <= fs_d;
    end
  end

  assign vga.Pixel_Tick_Out  = tick_q;
  assign vga.H_Sync_Out      = hs_q;
  assign vga.V_Sync_Out      = vs_q;
  assign vga.Disp_Ena_Out    = de_q;
  assign vga.Pixel_X_Out     = x_q;
  assign vga.Pixel_Y_Out     = y_q;
  assign vga.Frame_Start_Out = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing at CLK_DIV=4 and 1, plus a shrunken raster
// (16x10 totals) so frame wrap and mid-frame reset fit in a short run.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_if if_a ();
  vga_sync_if if_b ();
  vga_sync_if if_c ();

  vga_sync_gen #(.CLK_DIV(4)) dut_a (
    .Master_Clock_In(clk), .Reset_In(rst_a), .vga(if_a.master)
  );

  vga_sync_gen #(.CLK_DIV(1)) dut_b (
    .Master_Clock_In(clk), .Reset_In(rst_b), .vga(if_b.master)
  );

  // Small raster: H 8+2+3+3=16 (HS x=10..12), V 6+1+2+1=10 (VS y=7..8).
  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_c (
    .Master_Clock_In(clk), .Reset_In(rst_c), .vga(if_c.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int ex, ey, hs_low, vs_low, fs_cnt, fs_first, fs_last;

    // Reset held 5 cycles
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_tick", 32'(if_a.Pixel_Tick_Out), 32'd0);
    chk("rst_hs", 32'(if_a.H_Sync_Out), 32'd1);
    chk("rst_vs", 32'(if_a.V_Sync_Out), 32'd1);
    chk("rst_de", 32'(if_a.Disp_Ena_Out), 32'd0);
    chk("rst_x", 32'(if_a.Pixel_X_Out), 32'd0);
    chk("rst_y", 32'(if_a.Pixel_Y_Out), 32'd0);
    chk("rst_fs", 32'(if_a.Frame_Start_Out), 32'd0);

    // CLK_DIV=4: tick on every 4th cycle after release
    rst_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("div4_x", 32'(if_a.Pixel_X_Out), 32'(k / 4));
      chk("div4_y", 32'(if_a.Pixel_Y_Out), 32'd0);
      chk("div4_tick", 32'(if_a.Pixel_Tick_Out), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("div4_de", 32'(if_a.Disp_Ena_Out), 32'd1);
      chk("div4_fs", 32'(if_a.Frame_Start_Out), 32'd0);
    end

    // CLK_DIV=1: one full line of default timing
    rst_b  = 1'b0;
    hs_low = 0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      ex = k % 800;
      ey = k / 800;
      chk("line_x", 32'(if_b.Pixel_X_Out), 32'(ex));
      chk("line_y", 32'(if_b.Pixel_Y_Out), 32'(ey));
      chk("line_tick", 32'(if_b.Pixel_Tick_Out), 32'd1);
      chk("line_de", 32'(if_b.Disp_Ena_Out), (ex < 640) ? 32'd1 : 32'd0);
      chk("line_hs", 32'(if_b.H_Sync_Out), (ex >= 656 && ex < 752) ? 32'd0 : 32'd1);
      chk("line_vs", 32'(if_b.V_Sync_Out), 32'd1);
      if (if_b.H_Sync_Out === 1'b0) hs_low++;
    end
    chk("hs_width", 32'(hs_low), 32'd96);

    // Line wrap at X=799, Y=5
    for (int k = 801; k <= 4799; k++) @(negedge clk);
    chk("wrap_pre_x", 32'(if_b.Pixel_X_Out), 32'd799);
    chk("wrap_pre_y", 32'(if_b.Pixel_Y_Out), 32'd5);
    chk("wrap_pre_de", 32'(if_b.Disp_Ena_Out), 32'd0);
    @(negedge clk);
    chk("wrap_x", 32'(if_b.Pixel_X_Out), 32'd0);
    chk("wrap_y", 32'(if_b.Pixel_Y_Out), 32'd6);
    chk("wrap_hs", 32'(if_b.H_Sync_Out), 32'd1);
    chk("wrap_de", 32'(if_b.Disp_Ena_Out), 32'd1);
    chk("wrap_fs", 32'(if_b.Frame_Start_Out), 32'd0);

    // Small raster: two frame wraps, frame length 160 ticks
    rst_c    = 1'b0;
    vs_low   = 0;
    fs_cnt   = 0;
    fs_first = 0;
    fs_last  = 0;
    for (int k = 1; k <= 330; k++) begin
      @(negedge clk);
      ex = k % 16;
      ey = (k / 16) % 10;
      chk("frm_x", 32'(if_c.Pixel_X_Out), 32'(ex));
      chk("frm_y", 32'(if_c.Pixel_Y_Out), 32'(ey));
      chk("frm_fs", 32'(if_c.Frame_Start_Out), (k % 160 == 0) ? 32'd1 : 32'd0);
      chk("frm_vs", 32'(if_c.V_Sync_Out), (ey == 7 || ey == 8) ? 32'd0 : 32'd1);
      chk("frm_hs", 32'(if_c.H_Sync_Out), (ex >= 10 && ex <= 12) ? 32'd0 : 32'd1);
      chk("frm_de", 32'(if_c.Disp_Ena_Out), (ex < 8 && ey < 6) ? 32'd1 : 32'd0);
      if (if_c.V_Sync_Out === 1'b0) vs_low++;
      if (if_c.Frame_Start_Out === 1'b1) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = k;
        fs_last = k;
      end
    end
    chk("fs_count", 32'(fs_cnt), 32'd2);
    chk("frame_len", 32'(fs_last - fs_first), 32'd160);
    chk("vs_cycles", 32'(vs_low), 32'd64);

    // Mid-frame reset at X=5, Y=3
    for (int k = 331; k <= 373; k++) @(negedge clk);
    chk("mid_pre_x", 32'(if_c.Pixel_X_Out), 32'd5);
    chk("mid_pre_y", 32'(if_c.Pixel_Y_Out), 32'd3);
    rst_c = 1'b1;
    @(negedge clk);
    chk("mid_x", 32'(if_c.Pixel_X_Out), 32'd0);
    chk("mid_y", 32'(if_c.Pixel_Y_Out), 32'd0);
    chk("mid_de", 32'(if_c.Disp_Ena_Out), 32'd0);
    chk("mid_fs", 32'(if_c.Frame_Start_Out), 32'd0);
    chk("mid_hs", 32'(if_c.H_Sync_Out), 32'd1);
    chk("mid_vs", 32'(if_c.V_Sync_Out), 32'd1);
    chk("mid_tick", 32'(if_c.Pixel_Tick_Out), 32'd0);
    rst_c = 1'b0;
    @(negedge clk);
    chk("post_x", 32'(if_c.Pixel_X_Out), 32'd1);
    chk("post_y", 32'(if_c.Pixel_Y_Out), 32'd0);
    chk("post_tick", 32'(if_c.Pixel_Tick_Out), 32'd1);
    chk("post_fs", 32'(if_c.Frame_Start_Out), 32'd0);
    chk("post_de", 32'(if_c.Disp_Ena_Out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
